// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment codes, FSM state type and power-of-ten helper
package seg7_pkg;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Packed so that SEG_DIGIT[n] is the code for decimal n
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// rtl/seg7_digit_enc.sv - one BCD nibble to active-low 7-segment code
module seg7_digit_enc
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  // Dash wins over blank; nibbles 10..15 fall through to dash
  always_comb begin
    seg = SEG_DASH;
    if (dash)             seg = SEG_DASH;
    else if (blank)       seg = SEG_BLANK;
    else if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/bcd_seg_display.sv
// rtl/bcd_seg_display.sv - sequential binary-to-BCD converter driving DIGITS 7-segment digits
module bcd_seg_display
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DATA_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data,
  input  logic                  start,
  input  logic                  lzb_en,
  input  logic                  blink,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int          BCD_W = 4 * DIGITS;
  localparam int          CNT_W = $clog2(DATA_W + 1);
  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t              state, next_state;
  logic [DATA_W-1:0]   sreg;
  logic [BCD_W-1:0]    bcd, bcd_adj;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_q, lzb_q;
  logic [DIGITS-1:0]   blank;
  logic                seen;
  logic [7*DIGITS-1:0] enc_seg, digits;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (cnt == LAST_BIT) next_state = UPDATE;
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // Blank every digit above the most significant nonzero one; digit 0 always shows
  always_comb begin
    blank = '0;
    seen  = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (bcd[4*i +: 4] != 4'd0) seen = 1'b1;
      blank[i] = lzb_q & ~seen;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_digit_enc u_enc (
      .bcd   (bcd[4*g +: 4]),
      .blank (blank[g]),
      .dash  (ovf_q),
      .seg   (enc_seg[7*g +: 7])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      lzb_q    <= 1'b0;
      digits   <= {DIGITS{SEG_DIGIT[0]}};
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sreg  <= data;
          bcd   <= '0;
          cnt   <= '0;
          ovf_q <= 64'(data) > LIMIT;
          lzb_q <= lzb_en;
        end
        // Carries out of the top nibble are dropped; such values display as dashes
        SHIFT: begin
          {bcd, sreg} <= {bcd_adj[BCD_W-2:0], sreg, 1'b0};
          cnt         <= cnt + CNT_W'(1);
        end
        UPDATE: begin
          digits   <= enc_seg;
          overflow <= ovf_q;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign hex_out = blink ? '1 : digits;

endmodule

// File: tb/tb_bcd_seg_display.sv
// tb/tb_bcd_seg_display.sv - table-driven scoreboard bench for bcd_seg_display
module tb_bcd_seg_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;

  typedef struct {
    logic [13:0] data;
    logic        lzb;
    logic [27:0] hex;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [27:0] hex;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] data = '0;
  logic        start = 1'b0;
  logic        lzb_en = 1'b0;
  logic        blink = 1'b0;
  logic        busy, done, overflow;
  logic [27:0] hex_out;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  bcd_seg_display #(.DIGITS(4), .DATA_W(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .start    (start),
    .lzb_en   (lzb_en),
    .blink    (blink),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .hex_out  (hex_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_result(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({name, "_hex"}, {4'd0, hex_out}, {4'd0, e.hex});
      check({name, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
    end
  endtask

  // Start at the next edge T, then check busy over T+1..T+15 and done/result at T+16
  task automatic do_conv(input logic [13:0] d, input logic l, input logic [27:0] eh,
                         input logic eo, input string name);
    exp_t e;
    e.hex = eh;
    e.ovf = eo;
    sb_q.push_back(e);
    data = d; lzb_en = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      check({name, "_busy"}, {31'd0, busy}, 32'd1);
      check({name, "_nodone"}, {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    check_result(name);
  endtask

  initial begin
    int n_done;
    int done_at;

    vecs[0] = '{14'd1234,  1'b0, {S1, S2, S3, S4}, 1'b0};
    vecs[1] = '{14'd7,     1'b1, {SB, SB, SB, S7}, 1'b0};
    vecs[2] = '{14'd0,     1'b1, {SB, SB, SB, S0}, 1'b0};
    vecs[3] = '{14'd10000, 1'b0, {SD, SD, SD, SD}, 1'b1};
    vecs[4] = '{14'd9999,  1'b0, {S9, S9, S9, S9}, 1'b0};
    vecs[5] = '{14'd0,     1'b0, {S0, S0, S0, S0}, 1'b0};
    vecs[6] = '{14'd305,   1'b1, {SB, S3, S0, S5}, 1'b0};
    vecs[7] = '{14'd16383, 1'b1, {SD, SD, SD, SD}, 1'b1};
    vecs[8] = '{14'd1860,  1'b1, {S1, S8, S6, S0}, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_hex", {4'd0, hex_out}, {4'd0, S0, S0, S0, S0});
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);

    // Reset mid-conversion: rst sampled at edge T+5
    data = 14'd1234; lzb_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("midrst_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy_clr", {31'd0, busy}, 32'd0);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("midrst_no_done", n_done, 0);
    check("midrst_hex", {4'd0, hex_out}, {4'd0, S0, S0, S0, S0});

    for (int i = 0; i < 9; i++)
      do_conv(vecs[i].data, vecs[i].lzb, vecs[i].hex, vecs[i].ovf, $sformatf("vec%0d", i));

    // Busy rejection: second start at T+3 is ignored
    sb_q.push_back('{ {S0, S0, S4, S2}, 1'b0 });
    data = 14'd42; lzb_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    done_at = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin data = 14'd99; start = 1'b1; end
      if (k == 4) start = 1'b0;
      if (done) begin n_done++; done_at = k; end
      if (k < 16) @(negedge clk);
    end
    check("rej_done_count", n_done, 1);
    check("rej_done_at", done_at, 16);
    check_result("rej");

    // Back-to-back start in the done cycle
    sb_q.push_back('{ {S1, S2, S3, S4}, 1'b0 });
    data = 14'd1234; lzb_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    for (int k = 2; k <= 16; k++) @(negedge clk);
    check("b2b_done", {31'd0, done}, 32'd1);
    check_result("b2b");

    // Blink mask is combinational and leaves done/overflow alone
    @(negedge clk);
    blink = 1'b1;
    #1;
    check("blink_hex", {4'd0, hex_out}, 32'h0fff_ffff);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("blink_hold", {4'd0, hex_out}, 32'h0fff_ffff);
      check("blink_done", {31'd0, done}, 32'd0);
      check("blink_ovf", {31'd0, overflow}, 32'd0);
    end
    blink = 1'b0;
    #1;
    check("unblink_hex", {4'd0, hex_out}, {4'd0, S1, S2, S3, S4});
    check("unblink_ovf", {31'd0, overflow}, 32'd0);
    check("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_seg_display.md
Name: bcd_seg_display

Overview:
- Parametrised multi-digit decimal display driver for 7-segment time/value readouts.
- Takes a DATA_W-bit unsigned binary value on a start strobe and converts it sequentially to BCD (shift-add-3, one bit per clock).
- Registers DIGITS active-low 7-segment codes.
- Adds leading-zero blanking, overflow indication and whole-display blink.
- Used by display top levels in place of per-field fixed two-digit decoders.

Parameters:
- DIGITS, 4, number of decimal digits driven (1..8).
- DATA_W, 14, width of the binary input; default covers 0..9999.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- data  input  DATA_W  unsigned binary value; sampled only on an accepted start.
- start  input  1  request conversion; accepted only when busy=0.
- lzb_en  input  1  leading-zero blanking enable; sampled with data.
- blink  input  1  when 1, all segment outputs forced blank (combinational mask).
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when hex_out has been updated.
- overflow  output  1  registered; 1 if the last converted value exceeded 10^DIGITS-1.
- hex_out  output  7*DIGITS  digit i occupies bits [7i+6:7i]; digit 0 is the units digit. Segment order is {g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset is synchronous: on any edge with rst=1, all state is discarded, including a conversion in progress.
  - State returns to IDLE; busy=0, done=0, overflow=0.
  - Every digit register is set to 7'b1000000 ("0"), so the display reads 00..0 with the blink mask still applied.
- Segment codes for 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Blank is 1111111.
  - Dash is 0111111.
- FSM states:
  - IDLE:
    - On an edge with start=1, load shift register = data and BCD accumulator = 0.
    - Latch ovf = (data > 10^DIGITS-1) and latch lzb_en.
    - Clear the bit counter and go to SHIFT.
  - SHIFT:
    - Each edge adds 3 to every BCD nibble that is >= 5.
    - Then shift {bcd, sreg} left by one bit.
    - After exactly DATA_W edges, go to UPDATE.
  - UPDATE:
    - On one edge, write the digit registers, set overflow = ovf, pulse done=1 and return to IDLE.
- Width rules: BCD accumulator is 4*DIGITS bits; high-order carries beyond it are discarded. This is legal because overflow values are shown as dashes.
- Latency:
  - With the start edge at T, busy=1 from T+1 through T+DATA_W+1.
  - hex_out updates and done=1 at T+DATA_W+2; busy=0 in that same cycle.
  - A new start is accepted on that same edge.
- start while busy=1 is ignored; no queuing, and data is not resampled.
- Digit write rules in UPDATE:
  - If ovf=1, every digit shows dash.
  - Else if the latched lzb_en=1, every digit above the most significant nonzero digit is blank. Digit 0 is never blanked, so 0 shows as a single "0".
  - Else all digits are shown, including zeros.
- hex_out = blink ? all ones : digit registers. This is the only combinational path to an output.
- done is 0 in every cycle other than the UPDATE cycle. done and overflow are unaffected by blink.

Decomposition:
- Shared package seg7_pkg holds:
  - Segment constants SEG_BLANK and SEG_DASH.
  - Digit codes SEG_DIGIT[0..9].
  - A constant function pow10(n) used for the overflow limit.
- One combinational sub-module, seg7_digit_enc: 4-bit BCD in plus blank and dash controls in, 7-bit segments out. It is instantiated DIGITS times.
  - Out-of-range nibbles (10..15) encode as dash.
- The FSM, counter and shift-add-3 datapath stay in bcd_seg_display.

Test Plan (DIGITS=4, DATA_W=14):
- Reset mid-operation:
  - Stimulus: rst for 1 cycle after power-up, then start with data=1234, lzb_en=0, then rst=1 at T+5.
  - Required: after reset, hex_out = {1000000,1000000,1000000,1000000}, busy=0, done=0.
  - Required: after rst at T+5, busy=0 next cycle, no done pulse, and hex_out remains all "0".
- Nominal conversion:
  - Stimulus: start, data=1234, lzb_en=0 at edge T.
  - Required: busy=1 for cycles T+1..T+15, and done=1 only at T+16.
  - Required: hex_out = {0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1)} listed from digit 0 upward, i.e. display "1234", with overflow=0.
- Leading-zero blanking:
  - Stimulus: data=7 with lzb_en=1.
  - Required: digit0 = 1111000 and digits 1..3 = 1111111.
  - Stimulus: data=0 with lzb_en=1.
  - Required: digit0 = 1000000 and the rest blank.
- Overflow:
  - Stimulus: data=10000.
  - Required: all four digits = 0111111 and overflow=1.
  - Stimulus: follow-up data=9999.
  - Required: display "9999" (all digits 0010000) and overflow=0.
- Busy rejection:
  - Stimulus: start with data=42, then start with data=99 at T+3.
  - Required: exactly one done pulse at T+16, and the display reads 0042 (lzb_en=0).
  - Stimulus: back-to-back start asserted in the done cycle.
  - Required: that start is accepted, with busy=1 at the next cycle.
- Blink:
  - Stimulus: blink=1 while the display shows 1234.
  - Required: hex_out is all ones in the same cycle.
  - Stimulus: blink=0.
  - Required: "1234" returns immediately, and done and overflow are unchanged throughout.
